// File: rtl/axis_if.sv
// AXI4-Stream handshake bundle shared by the producer (master) and consumer (slave)
// sides of axis_reg_fifo.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_reg_fifo.sv
// DEPTH-word AXI4-Stream elastic buffer: registered ready, registered head word/valid,
// occupancy, almost-full and flush. Optional packet gating under AXIS_FIFO_PKT_EN.
module axis_reg_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1,
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  axis_if.slave                s_axis,
  axis_if.master               m_axis,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 almost_full,
  output logic [CNT_WIDTH-1:0] pkt_count
);
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C = CNT_WIDTH'(AFULL_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0] PTR_ZERO = {PTR_WIDTH{1'b0}};

  logic [WORD_WIDTH-1:0] mem_r [DEPTH];
  logic [WORD_WIDTH-1:0] head_r;
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic                  ready_r;
  logic                  valid_r;
  logic                  afull_r;

  logic                  accept_s;
  logic                  pop_s;
  logic [KEEP_WIDTH-1:0] keep_in_s;
  logic [WORD_WIDTH-1:0] in_word_s;
  logic [WORD_WIDTH-1:0] head_next_s;
  logic [PTR_WIDTH-1:0]  rd_next_s;
  logic [CNT_WIDTH-1:0]  count_next_s;
  logic                  valid_next_s;

  assign accept_s  = s_axis.tvalid & ready_r;
  assign pop_s     = valid_r & m_axis.tready;
  assign keep_in_s = (KEEP_ENABLE != 0) ? s_axis.tkeep : {KEEP_WIDTH{1'b1}};
  assign in_word_s = {s_axis.tdata, keep_in_s, s_axis.tlast, s_axis.tuser};

`ifdef AXIS_FIFO_PKT_EN
  logic [CNT_WIDTH-1:0] pkt_r;
  logic [CNT_WIDTH-1:0] pkt_next_s;
  logic                 head_last_s;

  assign head_last_s = head_r[USER_WIDTH];
  assign pkt_count   = pkt_r;

  // Next occupancy, packet count and output valid (valid waits for a whole packet or a full buffer)
  always_comb begin
    count_next_s = count_r + CNT_WIDTH'(accept_s) - CNT_WIDTH'(pop_s);
    pkt_next_s   = pkt_r + CNT_WIDTH'(accept_s & s_axis.tlast) - CNT_WIDTH'(pop_s & head_last_s);
    valid_next_s = (pkt_next_s != CNT_ZERO) || (count_next_s == DEPTH_C);
  end

  // Packet counter, cleared by reset and flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_r <= CNT_ZERO;
    end else if (flush) begin
      pkt_r <= CNT_ZERO;
    end else begin
      pkt_r <= pkt_next_s;
    end
  end
`else
  assign pkt_count = CNT_ZERO;

  // Next occupancy and output valid
  always_comb begin
    count_next_s = count_r + CNT_WIDTH'(accept_s) - CNT_WIDTH'(pop_s);
    valid_next_s = (count_next_s != CNT_ZERO);
  end
`endif

  // Head word for the next cycle: bypass the input when it lands in an otherwise empty buffer
  always_comb begin
    rd_next_s = rd_ptr_r + PTR_WIDTH'(pop_s);
    if (accept_s && (count_r == CNT_WIDTH'(pop_s))) begin
      head_next_s = in_word_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Control state: pointers, occupancy, ready, valid, almost_full
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      afull_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      afull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(accept_s);
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      ready_r  <= (count_next_s < DEPTH_C);
      valid_r  <= valid_next_s;
      afull_r  <= (count_next_s >= AFULL_C);
    end
  end

  // Datapath storage and output register; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= in_word_s;
    end
    head_r <= head_next_s;
  end

  assign s_axis.tready = ready_r;
  assign m_axis.tvalid = valid_r;
  assign m_axis.tuser  = head_r[USER_WIDTH-1:0];
  assign m_axis.tlast  = head_r[USER_WIDTH];
  assign m_axis.tkeep  = head_r[USER_WIDTH+KEEP_WIDTH:USER_WIDTH+1];
  assign m_axis.tdata  = head_r[WORD_WIDTH-1:WORD_WIDTH-DATA_WIDTH];
  assign count         = count_r;
  assign almost_full   = afull_r;
endmodule

// File: doc/axis_reg_fifo.md
Name: axis_reg_fifo

Overview:
- Parametrised successor to the single-stage AXI4-Stream skid register.
- Provides a DEPTH-word elastic buffer with a registered s_axis_tready, a registered output stage, occupancy and almost-full status, and a synchronous flush.
- Sits between producer/consumer stages of the accelerator datapath (pixel/weight streams), where one skid slot is not enough to absorb back-pressure bursts.

Parameters:
- DATA_WIDTH, 32, tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is all ones.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width (always propagated).
- DEPTH, 4, total word capacity; power of 2, >=2.
- AFULL_LEVEL, DEPTH-1, almost_full asserts when count >= AFULL_LEVEL; range 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH+1), width of count output.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  synchronous drop of all stored words
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input keep
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tlast  in  1  input last
- s_axis_tuser  in  USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tkeep  out  KEEP_WIDTH  output keep
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- m_axis_tuser  out  USER_WIDTH  output user
- count  out  CNT_WIDTH  words currently held, including the output register
- almost_full  out  1  count >= AFULL_LEVEL (registered)
- pkt_count  out  CNT_WIDTH  complete packets held (tlast words); tied 0 without the optional feature

Behaviour:
- Reset (rstn=0 at a clk edge): s_axis_tready=0, m_axis_tvalid=0, count=0, almost_full=0, pkt_count=0. Datapath registers are not reset.
- s_axis_tready goes to 1 on the first edge after rstn=1.
- Handshakes:
  - Input accept = s_axis_tvalid & s_axis_tready.
  - Output pop = m_axis_tvalid & m_axis_tready.
  - AXI rule: once m_axis_tvalid=1, m_axis_tdata/tkeep/tlast/tuser stay stable until pop.
- Ordering: strict FIFO; no word is lost or duplicated.
- Latency: a word accepted at edge t into an empty block shows m_axis_tvalid=1 after edge t, i.e. it is visible in cycle t+1. No bubble cycles at full throughput.
- Occupancy:
  - count_next = count + accept - pop.
  - Simultaneous accept and pop leaves count unchanged.
- Ready:
  - s_axis_tready_reg <= (count_next < DEPTH).
  - A block holding DEPTH words never asserts ready.
  - Ready returns 1 the edge after a pop from full.
- almost_full is registered from count_next, so it updates in the same cycle as count.
- Full boundary: at count=DEPTH with m_axis_tready=1, a pop occurs and ready rises next cycle; there is no simultaneous accept (ready was 0).
- Empty boundary: at count=0, m_axis_tvalid=0 and m_axis_tready is ignored; count never underflows.
- Pointers: the internal ring buffer read and write pointers wrap modulo the storage depth with no special case.
- Flush (rstn=1, flush=1 at an edge):
  - count, pkt_count and m_axis_tvalid go to 0; pointers are reset.
  - Any accept or pop in that cycle is discarded; the producer's word is lost by contract.
  - s_axis_tready=1 after the edge.
- Reset takes priority over flush. Reset mid-burst drops contents identically to flush but forces ready low for that edge.

Optional Feature:
- Macro: AXIS_FIFO_PKT_EN.
- Defined:
  - pkt_count increments on accept of a word with tlast=1 and decrements on pop of a word with tlast=1; both in the same cycle leaves it unchanged.
  - m_axis_tvalid asserts only when pkt_count>0, or when count=DEPTH (deadlock release for an oversize packet).
  - Latency for a single-word packet is unchanged (1 cycle).
- Undefined: pkt_count is tied 0 and m_axis_tvalid depends only on count>0.

Test Plan:
- Reset then idle, DEPTH=4, DATA_WIDTH=8: hold rstn=0 for 3 cycles, release -> s_axis_tready=0 during reset, 1 one cycle after release; m_axis_tvalid=0; count=0.
- Stream with m_axis_tready=1: send 0x01..0x10 every cycle -> outputs 0x01..0x10 in order, each 1 cycle after input; count stays 1; no bubbles.
- Fill with m_axis_tready=0: send 0xA0..0xA5 -> 0xA0..0xA3 accepted; ready=0 after the 4th accept; count=4; almost_full=1 from count=3. Then raise m_axis_tready -> pops 0xA0.., ready=1 next cycle, and 0xA4 accepted.
- Simultaneous accept+pop at count=2 -> count stays 2; data order preserved.
- Flush at count=3, with a concurrent input 0x55 valid -> count=0, m_axis_tvalid=0 next cycle, 0x55 not emitted, ready=1.
- AXIS_FIFO_PKT_EN defined: send 0x11, 0x22, 0x33(tlast) with m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after 0x33 is accepted, then 0x11, 0x22, 0x33 stream out; pkt_count goes 1 then 0. Also send 5 words without tlast -> valid asserts at count=4.
